// File: rtl/count_display_pkg.sv
// count_display_pkg
// Shared types and constants for the count display block: converter state
// encoding, BCD geometry, the blank segment pattern and the digit-to-segment
// lookup (active-low, bit order {g,f,e,d,c,b,a}).
package count_display_pkg;

  localparam int BIN_W = 8;               // width of the incoming binary count
  localparam int DIG_W = 4;               // one BCD digit
  localparam int N_DIG = 3;               // hundreds, tens, units
  localparam int BCD_W = DIG_W * N_DIG;   // 12-bit packed BCD
  localparam int SHR_W = BCD_W + BIN_W;   // double-dabble working register

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Digits 0..9 always decode; A..F decode only when hex_ok is set,
  // otherwise they show blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] nib, input logic hex_ok);
    logic [6:0] s;
    s = SEG_BLANK;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = hex_ok ? 7'h08 : SEG_BLANK;
      4'hB: s = hex_ok ? 7'h03 : SEG_BLANK;
      4'hC: s = hex_ok ? 7'h46 : SEG_BLANK;
      4'hD: s = hex_ok ? 7'h21 : SEG_BLANK;
      4'hE: s = hex_ok ? 7'h06 : SEG_BLANK;
      4'hF: s = hex_ok ? 7'h0E : SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/count_display_bin2bcd_seq.sv
// bin2bcd_seq
// Iterative double-dabble converter: 8-bit binary -> 3-digit BCD.
// Handshake: value_valid is a one-cycle sample strobe with no ready; a
// strobe while busy is held in a 1-deep pending slot (latest wins) and is
// started as soon as the FSM is back in IDLE, unless a fresh strobe arrives
// in that same IDLE cycle, which takes priority and discards the pending one.
// Ports:
//   clk, reset        clock, async active-high reset
//   value_in/valid    binary count and its sample strobe
//   conv_busy         FSM not in IDLE
//   conv_done         one-cycle pulse, bcd_out just updated
//   bcd_out           {hundreds, tens, units}
//   raw_out           binary of last completed conversion (HEX_MODE_EN only)
// Config macro: HEX_MODE_EN adds raw_out.
module bin2bcd_seq
  import count_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] value_in,
  input  logic             value_valid,
  output logic             conv_busy,
  output logic             conv_done,
`ifdef HEX_MODE_EN
  output logic [BIN_W-1:0] raw_out,
`endif
  output logic [BCD_W-1:0] bcd_out
);

  conv_state_t      r_state;
  logic [SHR_W-1:0] r_shift;
  logic [2:0]       r_iter;
  logic             r_pend;
  logic [BIN_W-1:0] r_pend_val;
  logic [BCD_W-1:0] r_bcd;
  logic             r_done;

  logic             w_load;
  logic [BIN_W-1:0] w_load_val;
  logic [SHR_W-1:0] w_adj;

  // A fresh strobe beats a stale pending value.
  assign w_load     = (r_state == ST_IDLE) && (value_valid || r_pend);
  assign w_load_val = value_valid ? value_in : r_pend_val;

  // Add-3 correction on every BCD nibble >= 5, applied before the shift.
  always_comb begin
    w_adj = r_shift;
    for (int d = 0; d < N_DIG; d++) begin
      if (r_shift[BIN_W + DIG_W*d +: DIG_W] >= 4'd5)
        w_adj[BIN_W + DIG_W*d +: DIG_W] = r_shift[BIN_W + DIG_W*d +: DIG_W] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_iter     <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_bcd      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != ST_IDLE) && value_valid) begin
        r_pend     <= 1'b1;
        r_pend_val <= value_in;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_shift <= {{BCD_W{1'b0}}, w_load_val};
            r_iter  <= '0;
            r_pend  <= 1'b0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_shift <= {w_adj[SHR_W-2:0], 1'b0};
          r_iter  <= r_iter + 3'd1;
          if (r_iter == 3'd7) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_bcd   <= r_shift[SHR_W-1:BIN_W];
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef HEX_MODE_EN
  // The shift register loses the binary operand, so keep a copy for hex view.
  logic [BIN_W-1:0] r_work;
  logic [BIN_W-1:0] r_raw;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_work <= '0;
      r_raw  <= '0;
    end else begin
      if (w_load) r_work <= w_load_val;
      if (r_state == ST_DONE) r_raw <= r_work;
    end
  end
  assign raw_out = r_raw;
`endif

  assign conv_busy = (r_state != ST_IDLE);
  assign conv_done = r_done;
  assign bcd_out   = r_bcd;

endmodule

// File: rtl/count_display.sv
// count_display
// Samples an 8-bit count, converts it to BCD and drives a multiplexed,
// active-low 3-digit 7-segment display with leading-zero blanking.
// Ports:
//   clk, reset        system clock, async active-high reset
//   value_in/valid    binary count and its sample strobe
//   hex_mode          (HEX_MODE_EN only) show raw value as two hex digits
//   conv_busy/done    converter status
//   bcd_out           last converted value in BCD
//   seg_n             {g,f,e,d,c,b,a}, active-low
//   an_n              digit enables, active-low, [0]=units .. [2]=hundreds
// Parameter SCAN_DIV: system clocks per digit slot (>= 2).
// Config macro: HEX_MODE_EN adds the hex_mode input and hex display.
module count_display
  import count_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] value_in,
  input  logic             value_valid,
`ifdef HEX_MODE_EN
  input  logic             hex_mode,
`endif
  output logic             conv_busy,
  output logic             conv_done,
  output logic [BCD_W-1:0] bcd_out,
  output logic [6:0]       seg_n,
  output logic [2:0]       an_n
);

  localparam int            PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic [1:0]       r_digit;
  logic [6:0]       r_seg_n;
  logic [2:0]       r_an_n;

  logic [BCD_W-1:0] w_bcd;
  logic             w_tick;
  logic [3:0]       w_nib;
  logic             w_blank;
  logic             w_hex;
  logic [6:0]       w_seg;

`ifdef HEX_MODE_EN
  logic [BIN_W-1:0] w_raw;
`endif

  bin2bcd_seq u_conv (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
    .conv_busy   (conv_busy),
    .conv_done   (conv_done),
`ifdef HEX_MODE_EN
    .raw_out     (w_raw),
`endif
    .bcd_out     (w_bcd)
  );

  assign w_tick = (r_presc == PRESC_LAST);

  // Select the nibble for the current slot and decide blanking.
  always_comb begin
    w_nib   = w_bcd[3:0];
    w_blank = 1'b0;
    w_hex   = 1'b0;
    case (r_digit)
      2'd0: w_nib = w_bcd[3:0];
      2'd1: begin
        w_nib   = w_bcd[7:4];
        w_blank = (w_bcd[11:8] == 4'd0) && (w_bcd[7:4] == 4'd0);
      end
      2'd2: begin
        w_nib   = w_bcd[11:8];
        w_blank = (w_bcd[11:8] == 4'd0);
      end
      default: w_blank = 1'b1;
    endcase
`ifdef HEX_MODE_EN
    if (hex_mode) begin
      w_hex = 1'b1;
      case (r_digit)
        2'd0:    begin w_nib = w_raw[3:0]; w_blank = 1'b0; end
        2'd1:    begin w_nib = w_raw[7:4]; w_blank = 1'b0; end
        default: w_blank = 1'b1;
      endcase
    end
`endif
    w_seg = w_blank ? SEG_BLANK : seg_encode(w_nib, w_hex);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_digit <= 2'd0;
      r_seg_n <= SEG_BLANK;
      r_an_n  <= 3'b111;
    end else if (w_tick) begin
      r_presc <= '0;
      r_seg_n <= w_seg;
      r_an_n  <= ~(3'b001 << r_digit);
      r_digit <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign bcd_out = w_bcd;
  assign seg_n   = r_seg_n;
  assign an_n    = r_an_n;

endmodule

// File: tb/tb_count_display.sv
// tb_count_display
// Bench for count_display with SCAN_DIV=4. A timeline model predicts, per
// clock, busy/done and which values get converted; displayed segments are
// predicted from decimal/hex digit arithmetic. Build with +define+HEX_MODE_EN
// to include the hex display sequence.
module tb_count_display;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  value_in;
  logic        value_valid;
  logic        hex_mode;
  logic        conv_busy;
  logic        conv_done;
  logic [11:0] bcd_out;
  logic [6:0]  seg_n;
  logic [2:0]  an_n;

  int n_checks = 0;
  int n_errors = 0;

  count_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_valid (value_valid),
`ifdef HEX_MODE_EN
    .hex_mode    (hex_mode),
`endif
    .conv_busy   (conv_busy),
    .conv_done   (conv_done),
    .bcd_out     (bcd_out),
    .seg_n       (seg_n),
    .an_n        (an_n)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [11:0] exp_q[$];    // expected BCD results in completion order
  bit  m_started;
  int  m_s;                 // edge index at which the current conversion began
  int  m_e;                 // edge index of the next edge
  int  m_cur;
  bit  m_pend;
  int  m_pend_val;
  int  m_last;              // value of last completed conversion
  int  n_done;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; 15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  // dig: 0=units 1=tens 2=hundreds
  function automatic logic [6:0] exp_seg(input int v, input int dig, input bit hex);
    int h, t, u;
    if (hex) begin
      if (dig == 0) return glyph(v % 16);
      if (dig == 1) return glyph(v / 16);
      return 7'h7F;
    end
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    if (dig == 2) return (h == 0) ? 7'h7F : glyph(h);
    if (dig == 1) return (h == 0 && t == 0) ? 7'h7F : glyph(t);
    return glyph(u);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_started = 0; m_s = 0; m_e = 0; m_cur = 0;
    m_pend = 0; m_pend_val = 0; m_last = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- driver: one clock edge with model update and checks ----------------
  task automatic step(input bit v, input int x);
    bit idle_now, exp_busy, exp_done;
    value_valid = v;
    value_in    = 8'(x);
    idle_now = !m_started || (m_e >= m_s + 10);
    if (idle_now) begin
      if (v || m_pend) begin
        m_cur = v ? x : m_pend_val;
        m_started = 1; m_s = m_e; m_pend = 0;
        exp_q.push_back(to_bcd(m_cur));
      end
    end else if (v) begin
      m_pend = 1; m_pend_val = x;
    end
    @(negedge clk);
    exp_busy = m_started && (m_e >= m_s) && (m_e <= m_s + 8);
    exp_done = m_started && (m_e == m_s + 9);
    chk("conv_busy", 32'(conv_busy), 32'(exp_busy));
    chk("conv_done", 32'(conv_done), 32'(exp_done));
    if (conv_done) begin
      n_done++;
      if (exp_q.size() == 0) chk("unexpected_done", 32'(bcd_out), 32'hFFFF_FFFF);
      else chk("bcd_out", 32'(bcd_out), 32'(exp_q.pop_front()));
    end
    if (exp_done) m_last = m_cur;
    m_e++;
  endtask

  // Let all three slots refresh, then watch one full 12-clock scan period.
  task automatic check_disp(input string nm, input logic [6:0] eu, input logic [6:0] et,
                            input logic [6:0] eh);
    logic [6:0] seen[3];
    int cnt[3];
    int bad_order, bad_an;
    logic [2:0] prev;
    repeat (3 * SCAN_DIV) step(0, 0);
    seen = '{7'h00, 7'h00, 7'h00};
    cnt = '{0, 0, 0};
    bad_order = 0; bad_an = 0;
    prev = an_n;
    for (int i = 0; i < 3 * SCAN_DIV; i++) begin
      step(0, 0);
      case (an_n)
        3'b110:  begin cnt[0]++; seen[0] = seg_n; end
        3'b101:  begin cnt[1]++; seen[1] = seg_n; end
        3'b011:  begin cnt[2]++; seen[2] = seg_n; end
        default: bad_an++;
      endcase
      if (an_n != prev && an_n != {prev[1:0], prev[2]}) bad_order++;
      prev = an_n;
    end
    chk({nm, "_units"}, 32'(seen[0]), 32'(eu));
    chk({nm, "_tens"}, 32'(seen[1]), 32'(et));
    chk({nm, "_hund"}, 32'(seen[2]), 32'(eh));
    chk({nm, "_slots"}, 32'(cnt[0] == SCAN_DIV && cnt[1] == SCAN_DIV && cnt[2] == SCAN_DIV
                            && bad_an == 0 && bad_order == 0), 32'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int          v;
    logic [11:0] bcd;
    logic [6:0]  su, st, sh;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int done_before;
    tbl[0] = '{255, 12'h255, 7'h12, 7'h12, 7'h24};
    tbl[1] = '{7,   12'h007, 7'h78, 7'h7F, 7'h7F};
    tbl[2] = '{0,   12'h000, 7'h40, 7'h7F, 7'h7F};
    tbl[3] = '{10,  12'h010, 7'h40, 7'h79, 7'h7F};
    tbl[4] = '{100, 12'h100, 7'h40, 7'h40, 7'h79};
    tbl[5] = '{99,  12'h099, 7'h10, 7'h10, 7'h7F};

    reset = 1'b1; value_valid = 1'b0; value_in = 8'h00; hex_mode = 1'b0;
    n_done = 0;
    model_reset();
    #1;
    chk("rst_busy", 32'(conv_busy), 32'd0);
    chk("rst_done", 32'(conv_done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_seg", 32'(seg_n), 32'h7F);
    chk("rst_an", 32'(an_n), 32'b111);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Dark until first scan tick.
    step(0, 0);
    chk("dark_seg", 32'(seg_n), 32'h7F);
    chk("dark_an", 32'(an_n), 32'b111);

    // Table-driven conversions and display.
    for (int i = 0; i < 6; i++) begin
      step(1, tbl[i].v);
      repeat (11) step(0, 0);
      chk($sformatf("tbl%0d_bcd", i), 32'(bcd_out), 32'(tbl[i].bcd));
      check_disp($sformatf("tbl%0d", i), tbl[i].su, tbl[i].st, tbl[i].sh);
    end

    // Strobes while busy: latest pending wins, 42 is dropped.
    done_before = n_done;
    step(1, 100); step(0, 0); step(1, 42); step(0, 0); step(1, 200);
    repeat (25) step(0, 0);
    chk("pend_dones", 32'(n_done - done_before), 32'd2);
    chk("pend_final", 32'(bcd_out), 32'h200);

    // Fresh strobe in the IDLE cycle beats the pending value.
    step(1, 11); step(0, 0); step(1, 22);
    repeat (7) step(0, 0);
    step(1, 33);
    repeat (12) step(0, 0);
    chk("fresh_wins", 32'(bcd_out), 32'h033);

    // Reset in the middle of converting 99.
    step(1, 99);
    repeat (4) step(0, 0);
    #2;
    reset = 1'b1; value_valid = 1'b1; value_in = 8'd99;
    #1;
    chk("mid_rst_busy", 32'(conv_busy), 32'd0);
    chk("mid_rst_bcd", 32'(bcd_out), 32'd0);
    chk("mid_rst_seg", 32'(seg_n), 32'h7F);
    chk("mid_rst_an", 32'(an_n), 32'b111);
    repeat (2) @(negedge clk);
    reset = 1'b0; value_valid = 1'b0;
    model_reset();
    done_before = n_done;
    repeat (20) step(0, 0);
    chk("post_rst_bcd", 32'(bcd_out), 32'd0);
    chk("post_rst_dones", 32'(n_done - done_before), 32'd0);

    // Random strobes against the timeline model.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 255)));
    repeat (25) step(0, 0);
    chk("rand_drain", 32'(exp_q.size()), 32'd0);

    // Random values through the display.
    for (int i = 0; i < 6; i++) begin
      step(1, int'($urandom_range(0, 255)));
      repeat (11) step(0, 0);
      check_disp($sformatf("rdisp%0d", i), exp_seg(m_last, 0, hex_mode),
                 exp_seg(m_last, 1, hex_mode), exp_seg(m_last, 2, hex_mode));
    end

`ifdef HEX_MODE_EN
    step(1, 8'hA5);
    repeat (11) step(0, 0);
    hex_mode = 1'b1;
    check_disp("hex_a5", 7'h12, 7'h08, 7'h7F);
    hex_mode = 1'b0;
    check_disp("dec_a5", 7'h12, 7'h02, 7'h79);
    for (int i = 0; i < 4; i++) begin
      step(1, int'($urandom_range(0, 255)));
      repeat (11) step(0, 0);
      hex_mode = 1'b1;
      check_disp($sformatf("rhex%0d", i), exp_seg(m_last, 0, 1'b1),
                 exp_seg(m_last, 1, 1'b1), exp_seg(m_last, 2, 1'b1));
      hex_mode = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
